// File: rtl/uart_tx_arbiter.sv
// uart_tx_arbiter: round-robin arbiter sharing one UART transmitter among NumReq requesters,
// with a watchdog that abandons a frame whose done tick never arrives.
module uart_tx_arbiter #(
   parameter int unsigned NumReq        = 4,
   parameter int unsigned WordLength    = 8,
   parameter int unsigned TimeoutCycles = 65535,
   localparam int unsigned IdW          = (NumReq > 1) ? $clog2(NumReq) : 1
) (
   input  logic                         clk_i,
   input  logic                         rst_ni,
   input  logic [NumReq-1:0]            req_valid_i,
   input  logic [NumReq*WordLength-1:0] req_data_i,
   output logic [NumReq-1:0]            req_ready_o,
   output logic                         tx_start_o,
   output logic [WordLength-1:0]        tx_data_o,
   input  logic                         tx_done_tick_i,
   output logic [IdW-1:0]               grant_id_o,
   output logic                         busy_o,
   output logic                         timeout_o
);

   typedef enum logic [1:0] {StIdle, StStart, StWait} state_e;

   localparam logic [15:0]    WdogLast = 16'(TimeoutCycles - 1);
   localparam logic [IdW-1:0] LastReq  = IdW'(NumReq - 1);

   state_e                state_q, state_d;
   logic [IdW-1:0]        last_grant_q, last_grant_d;
   logic [IdW-1:0]        grant_id_q, grant_id_d;
   logic [WordLength-1:0] tx_data_q, tx_data_d;
   logic [15:0]           wdog_q, wdog_d;
   logic [IdW-1:0]        winner;
   logic                  any_valid;
   logic [WordLength-1:0] data_arr [NumReq];

   for (genvar k = 0; k < NumReq; k++) begin : g_unpack
      assign data_arr[k] = req_data_i[k*WordLength +: WordLength];
   end

   // Scan offsets from far to near so the nearest set bit after 'last' wins.
   function automatic logic [IdW-1:0] rr_pick(input logic [NumReq-1:0] v,
                                              input logic [IdW-1:0]    last);
      logic [IdW-1:0] w;
      int unsigned    idx;
      logic [IdW-1:0] idx_w;
      w = last;
      for (int i = NumReq; i >= 1; i--) begin
         idx   = (int'(last) + i) % NumReq;
         idx_w = idx[IdW-1:0];
         if (v[idx_w]) w = idx_w;
      end
      return w;
   endfunction

   assign any_valid = |req_valid_i;
   assign winner    = rr_pick(req_valid_i, last_grant_q);

   always_comb begin
      state_d      = state_q;
      last_grant_d = last_grant_q;
      grant_id_d   = grant_id_q;
      tx_data_d    = tx_data_q;
      wdog_d       = wdog_q;
      req_ready_o  = '0;
      tx_start_o   = 1'b0;
      timeout_o    = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (any_valid) begin
               // Ready is masked while reset is held so nothing is offered during reset.
               req_ready_o[winner] = rst_ni;
               last_grant_d        = winner;
               grant_id_d          = winner;
               tx_data_d           = data_arr[winner];
               state_d             = StStart;
            end
         end
         StStart: begin
            tx_start_o = 1'b1;
            wdog_d     = '0;
            state_d    = StWait;
         end
         StWait: begin
            if (tx_done_tick_i) begin
               state_d = StIdle;
            end else if (wdog_q == WdogLast) begin
               timeout_o = 1'b1;
               state_d   = StIdle;
            end else begin
               wdog_d = wdog_q + 16'd1;
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q      <= StIdle;
         last_grant_q <= LastReq;
         grant_id_q   <= '0;
         tx_data_q    <= '0;
         wdog_q       <= '0;
      end else begin
         state_q      <= state_d;
         last_grant_q <= last_grant_d;
         grant_id_q   <= grant_id_d;
         tx_data_q    <= tx_data_d;
         wdog_q       <= wdog_d;
      end
   end

   assign busy_o     = (state_q != StIdle);
   assign tx_data_o  = tx_data_q;
   assign grant_id_o = grant_id_q;

endmodule

// File: doc/uart_tx_arbiter.md
UART_TX_ARBITER -- requirements
Module: uart_tx_arbiter

Interface
REQ-001 Parameter NumReq, default 4, number of requesters sharing one UART transmitter (2..8).
REQ-002 Parameter WordLength, default 8, data bits per frame.
REQ-003 Parameter TimeoutCycles, default 65535, clk_i cycles allowed in WAIT before abort (1..65535).
REQ-004 The block SHALL use one clock and an asynchronous, active-low reset.
REQ-005 clk_i  input  1  clock, all state on rising edge.
REQ-006 rst_ni  input  1  asynchronous active-low reset.
REQ-007 req_valid_i  input  NumReq  per-requester frame-valid.
REQ-008 req_data_i  input  NumReq*WordLength  flattened data, requester k at bits [k*WordLength +: WordLength].
REQ-009 req_ready_o  output  NumReq  per-requester accept, one-hot or zero.
REQ-010 tx_start_o  output  1  one-cycle start pulse to transmitter.
REQ-011 tx_data_o  output  WordLength  frame data to transmitter.
REQ-012 tx_done_tick_i  input  1  transmitter frame-complete pulse.
REQ-013 grant_id_o  output  $clog2(NumReq)  index of requester currently owning the transmitter.
REQ-014 busy_o  output  1  high in START and WAIT.
REQ-015 timeout_o  output  1  one-cycle pulse on watchdog abort.

Function
REQ-016 FSM states SHALL be IDLE, START, WAIT.
REQ-017 IDLE: if any req_valid_i bit set, winner SHALL be first set bit searching from last_grant+1 upward, wrapping modulo NumReq.
REQ-018 IDLE: req_ready_o[winner] SHALL be asserted combinationally in the same cycle; handshake completes when valid and ready are both high.
REQ-019 On handshake: winner's data latched into tx_data register, grant_id_o and last_grant updated to winner, next state START.
REQ-020 IDLE with no valid: all req_ready_o low, state held.
REQ-021 START: tx_start_o high for exactly one cycle, watchdog cleared, next state WAIT.
REQ-022 WAIT: tx_data_o and grant_id_o SHALL remain stable; req_ready_o all low regardless of req_valid_i.
REQ-023 WAIT: tx_done_tick_i high SHALL return FSM to IDLE next cycle; new grant possible in that IDLE cycle (minimum 3 cycles per frame excluding transmitter time).
REQ-024 tx_done_tick_i SHALL be ignored in IDLE and START.
REQ-025 Watchdog: 16-bit counter increments each WAIT cycle; when it reaches TimeoutCycles-1 without tx_done_tick_i, timeout_o pulses one cycle and FSM goes to IDLE; last_grant retains aborted requester.
REQ-026 tx_done_tick_i and watchdog expiry in the same cycle: done wins, no timeout_o.
REQ-027 Requester deasserting req_valid_i before handshake SHALL simply lose arbitration; no state change.
REQ-028 Only one requester SHALL be accepted per frame; no data from non-winners captured.

Reset
REQ-029 rst_ni low SHALL immediately force: state IDLE, req_ready_o 0, tx_start_o 0, tx_data_o 0, grant_id_o 0, busy_o 0, timeout_o 0, watchdog 0, last_grant NumReq-1 (requester 0 highest priority first).
REQ-030 Reset asserted in START or WAIT SHALL discard the in-flight frame with no tx_start_o and no timeout_o.

Verification
REQ-031 Reset: rst_ni low with random inputs -> all outputs 0, req_ready_o 0; release, valid[0]=1 -> ready[0]=1 same cycle.
REQ-032 Single requester: valid[2]=1, data[2]=0xA5 -> ready[2] one cycle, tx_start_o next cycle with tx_data_o=0xA5, grant_id_o=2, busy_o high until cycle after tx_done_tick_i.
REQ-033 Round-robin: valid=4'b1111 held, done 5 cycles after each start -> grant order 0,1,2,3,0 with distinct data per requester observed on tx_data_o.
REQ-034 Blocking: valid[1] asserted during WAIT -> req_ready_o stays 0 until done, then ready[1] in following IDLE cycle.
REQ-035 Timeout: TimeoutCycles=10, no done -> timeout_o pulse 10 cycles into WAIT, IDLE next; pending valid[3] then granted; done+expiry same cycle -> no timeout_o.
REQ-036 Reset mid-frame: rst_ni low in WAIT -> outputs 0 immediately; after release, valid=4'b0011 -> requester 0 granted first.
